// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, FSM state and region types shared by the data-memory stage
package dmem_pkg;
  localparam logic [3:0] LED_OFF = 4'h0;
  localparam logic [3:0] SW_OFF  = 4'h4;
  localparam logic [3:0] CNT_OFF = 4'h8;

  typedef enum logic [0:0] {IDLE, LOAD_WAIT} dmem_state_t;
  typedef enum logic [1:0] {REGION_RAM, REGION_IO, REGION_NONE} region_t;

  // RAM wins over IO so a misplaced IO window can never shadow RAM words
  function automatic region_t decode(input logic [31:0] addr, input int unsigned depth,
                                     input logic [31:0] io_base);
    return addr < 32'(4 * depth) ? REGION_RAM :
           addr[31:4] == io_base[31:4] ? REGION_IO : REGION_NONE;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous-read, write-first word RAM
module dmem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Registered read port; a write returns the new word on the same edge
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata <= i_wdata;
    end else r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_interface.sv
// dmem_interface: data-memory stage with synchronous RAM, memory-mapped I/O and load stall
module dmem_interface
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] IO_BASE = 32'h0000_F000,
  parameter int          LED_W   = 8,
  parameter int          SW_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Stall,
  output logic             MemFault,
  input  logic [SW_W-1:0]  switches_in,
  output logic [LED_W-1:0] leds_out
);
  localparam int AW = $clog2(DEPTH);

  dmem_state_t      r_state, w_next;
  region_t          w_region;
  logic [3:0]       w_off;
  logic             w_fault, w_rd_ok, w_wr_ok, w_ram_ld, w_ram_we, w_led_we, w_cnt_clr;
  logic [31:0]      w_ram_q, w_io_q;
  logic [LED_W-1:0] r_leds;
  logic [SW_W-1:0]  r_sw_meta, r_sw_sync;
  logic [31:0]      r_cnt;
  logic             r_fault;

  assign w_region = decode(ALUResult, DEPTH, IO_BASE);

  // Qualify the request against the state, pick the next state and steer load data
  always_comb begin
    w_off = ALUResult[3:0];
    w_fault = r_state == IDLE && (MemRead || MemWrite) &&
              (|ALUResult[1:0] || w_region == REGION_NONE || (MemRead && MemWrite));
    w_rd_ok = r_state == IDLE && MemRead && !w_fault;
    w_wr_ok = r_state == IDLE && MemWrite && !w_fault;
    w_ram_ld = w_rd_ok && w_region == REGION_RAM;
    w_ram_we = w_wr_ok && w_region == REGION_RAM && reset;
    w_led_we = w_wr_ok && w_region == REGION_IO && w_off == LED_OFF;
    w_cnt_clr = w_wr_ok && w_region == REGION_IO && w_off == CNT_OFF;
    w_io_q = w_off == LED_OFF ? 32'(r_leds) :
             w_off == SW_OFF  ? 32'(r_sw_sync) :
             w_off == CNT_OFF ? r_cnt : 32'h0;
    Stall = w_ram_ld;
    ReadData = r_state == LOAD_WAIT ? w_ram_q :
               (w_rd_ok && w_region == REGION_IO) ? w_io_q : 32'h0;
    w_next = r_state == LOAD_WAIT ? IDLE : w_ram_ld ? LOAD_WAIT : IDLE;
  end

  // Load FSM state register; a reset abandons any load in flight
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  // I/O registers, fault pulse, switch synchroniser and free-running counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_leds <= '0;
      r_fault <= 1'b0;
      r_cnt <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_leds <= w_led_we ? WriteData[LED_W-1:0] : r_leds;
      r_fault <= w_fault;
      r_cnt <= w_cnt_clr ? 32'h0 : r_cnt + 32'd1;
      r_sw_meta <= switches_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign MemFault = r_fault;
  assign leds_out = r_leds;

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (ALUResult[AW+1:2]),
    .i_wdata(WriteData),
    .o_rdata(w_ram_q)
  );
endmodule

// File: tb/tb_dmem_interface.sv
// tb_dmem_interface: directed table, corner sequences and random traffic against a transaction model
module tb_dmem_interface;
  localparam int          DEPTH   = 1024;
  localparam logic [31:0] IO      = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        reset, MemRead, MemWrite, Stall, MemFault;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic [7:0]  switches_in, leds_out;

  dmem_interface #(.DEPTH(DEPTH), .IO_BASE(IO), .LED_W(8), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .MemFault(MemFault), .switches_in(switches_in), .leds_out(leds_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_on = 1'b0;

  logic [31:0] m_mem [DEPTH];
  logic        m_pend = 1'b0, m_fault = 1'b0;
  logic [31:0] m_pdata = 0, m_cnt = 0;
  logic [7:0]  m_leds = 0, m_sw_mid = 0, m_sw_vis = 0;
  logic        got_st, got_f;
  logic [31:0] got_rd;
  logic [7:0]  got_led;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] io_val(input logic [3:0] off);
    return off == 4'h0 ? 32'(m_leds) : off == 4'h4 ? 32'(m_sw_vis) :
           off == 4'h8 ? m_cnt : 32'h0;
  endfunction

  task automatic cycle(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [7:0] sw, input logic rn);
    logic ram, io, bad, e_st;
    logic [31:0] e_rd;
    int idx;
    MemRead = rd; MemWrite = wr; ALUResult = a; WriteData = wd; switches_in = sw; reset = rn;
    ram = a < 32'(4 * DEPTH);
    io = !ram && a[31:4] == IO[31:4];
    bad = !m_pend && (rd || wr) && (a[1:0] != 2'b00 || !(ram || io) || (rd && wr));
    idx = int'(a[11:2]);
    e_st = !m_pend && rd && !bad && ram;
    e_rd = m_pend ? m_pdata : (rd && !bad && io) ? io_val(a[3:0]) : 32'h0;
    @(negedge clk);
    got_st = Stall; got_rd = ReadData; got_f = MemFault; got_led = leds_out;
    if (chk_on) begin
      chk("model_stall", 32'(Stall), 32'(e_st));
      chk("model_rdata", ReadData, e_rd);
      chk("model_fault", 32'(MemFault), 32'(m_fault));
      chk("model_leds", 32'(leds_out), 32'(m_leds));
    end
    @(posedge clk); #1;
    if (!rn) begin
      m_pend = 0; m_fault = 0; m_leds = 0; m_cnt = 0; m_sw_mid = 0; m_sw_vis = 0;
    end else begin
      m_fault = bad;
      if (!m_pend && !bad && wr && ram) m_mem[idx] = wd;
      if (!m_pend && !bad && wr && io && a[3:0] == 4'h0) m_leds = wd[7:0];
      m_cnt = (!m_pend && !bad && wr && io && a[3:0] == 4'h8) ? 32'h0 : m_cnt + 1;
      m_sw_vis = m_sw_mid;
      m_sw_mid = sw;
      if (m_pend) m_pend = 0;
      else if (e_st) begin m_pend = 1; m_pdata = m_mem[idx]; end
    end
  endtask

  typedef struct {
    logic rd, wr; logic [31:0] a, wd; logic [7:0] sw;
    logic st; logic [31:0] rdv; logic f; logic [7:0] led;
  } vec_t;

  function automatic vec_t v(logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic [7:0] sw,
                             logic st, logic [31:0] rdv, logic f, logic [7:0] led);
    vec_t t;
    t.rd = rd; t.wr = wr; t.a = a; t.wd = wd; t.sw = sw; t.st = st; t.rdv = rdv; t.f = f; t.led = led;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    logic rd, wr, rn;
    logic [31:0] a, wd, last_a;
    tbl.push_back(v(1, 0, IO + 8,   0,            0,    0, 0,            0, 8'h00));
    tbl.push_back(v(0, 1, 32'h8,    32'h12345678, 0,    0, 0,            0, 8'h00));
    tbl.push_back(v(1, 0, 32'h8,    0,            0,    1, 0,            0, 8'h00));
    tbl.push_back(v(1, 0, 32'h8,    0,            0,    0, 32'h12345678, 0, 8'h00));
    tbl.push_back(v(0, 0, 0,        0,            0,    0, 0,            0, 8'h00));
    tbl.push_back(v(0, 1, 32'h0,    32'hA,        0,    0, 0,            0, 8'h00));
    tbl.push_back(v(0, 1, 32'h4,    32'h5,        0,    0, 0,            0, 8'h00));
    tbl.push_back(v(1, 0, 32'h0,    0,            0,    1, 0,            0, 8'h00));
    tbl.push_back(v(1, 0, 32'h0,    0,            0,    0, 32'hA,        0, 8'h00));
    tbl.push_back(v(1, 0, 32'h4,    0,            0,    1, 0,            0, 8'h00));
    tbl.push_back(v(1, 0, 32'h4,    0,            0,    0, 32'h5,        0, 8'h00));
    tbl.push_back(v(0, 1, IO,       32'hFF,       0,    0, 0,            0, 8'h00));
    tbl.push_back(v(0, 0, 0,        0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(0, 0, 0,        0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, IO + 4,   0,            8'h3C, 0, 32'h3C,      0, 8'hFF));
    tbl.push_back(v(1, 0, 32'h2002, 0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, 32'h5000, 0,            8'h3C, 0, 0,           1, 8'hFF));
    tbl.push_back(v(1, 1, 32'h0,    32'hDEAD,     8'h3C, 0, 0,           1, 8'hFF));
    tbl.push_back(v(0, 0, 0,        0,            8'h3C, 0, 0,           1, 8'hFF));
    tbl.push_back(v(0, 0, 0,        0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, 32'h0,    0,            8'h3C, 1, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, 32'h0,    0,            8'h3C, 0, 32'hA,       0, 8'hFF));
    tbl.push_back(v(0, 1, IO + 4,   32'h77,       8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, IO + 12,  0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, IO,       0,            8'h3C, 0, 32'hFF,      0, 8'hFF));
    tbl.push_back(v(0, 1, 32'hFFC,  32'hCAFEF00D, 8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, 32'hFFC,  0,            8'h3C, 1, 0,           0, 8'hFF));
    tbl.push_back(v(1, 0, 32'hFFC,  0,            8'h3C, 0, 32'hCAFEF00D, 0, 8'hFF));
    tbl.push_back(v(1, 0, 32'h1000, 0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(0, 0, 0,        0,            8'h3C, 0, 0,           1, 8'hFF));
    tbl.push_back(v(1, 0, IO + 16,  0,            8'h3C, 0, 0,           0, 8'hFF));
    tbl.push_back(v(0, 0, 0,        0,            8'h3C, 0, 0,           1, 8'hFF));
    tbl.push_back(v(1, 0, IO + 4,   0,            8'h3C, 0, 32'h3C,      0, 8'hFF));

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].sw, 1);
      chk($sformatf("row%0d_stall", i), 32'(got_st), 32'(tbl[i].st));
      chk($sformatf("row%0d_rdata", i), got_rd, tbl[i].rdv);
      chk($sformatf("row%0d_fault", i), 32'(got_f), 32'(tbl[i].f));
      chk($sformatf("row%0d_leds", i), 32'(got_led), 32'(tbl[i].led));
    end

    cycle(0, 1, IO + 8, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, IO + 8, 0, 0, 1);
    chk("counter_10", got_rd, 32'hA);

    cycle(1, 0, 32'h8, 0, 0, 1);
    chk("rst_load_stall", 32'(got_st), 32'h1);
    cycle(1, 0, 32'h8, 0, 0, 0);
    chk("rst_wait_stall", 32'(got_st), 32'h0);
    chk("rst_wait_rdata", got_rd, 32'h12345678);
    cycle(1, 0, IO + 8, 0, 0, 1);
    chk("post_rst_stall", 32'(got_st), 32'h0);
    chk("post_rst_cnt", got_rd, 32'h0);
    chk("post_rst_leds", 32'(got_led), 32'h0);
    chk("post_rst_fault", 32'(got_f), 32'h0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 32'h8, 0, 0, 1);
    chk("ram_kept_stall", 32'(got_st), 32'h1);
    cycle(1, 0, 32'h8, 0, 0, 1);
    chk("ram_kept_rdata", got_rd, 32'h12345678);

    for (int i = 0; i < 16; i++) cycle(0, 1, 32'(4 * i), $urandom, 8'($urandom), 1);

    last_a = 0;
    for (int n = 0; n < 800; n++) begin
      rn = $urandom_range(0, 63) != 0;
      wd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: begin rd = 1; wr = 0; a = 32'(4 * $urandom_range(0, 15)); end
        3, 4:    begin rd = 0; wr = 1; a = 32'(4 * $urandom_range(0, 15)); end
        5:       begin rd = 1; wr = 0; a = IO + 32'(4 * $urandom_range(0, 3)); end
        6:       begin rd = 0; wr = 1; a = IO + 32'(4 * $urandom_range(0, 3)); end
        7:       begin rd = $urandom_range(0, 1) == 1; wr = !rd;
                       a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3)); end
        8:       begin rd = 1; wr = 0; a = 32'h5000 + 32'(4 * $urandom_range(0, 15)); end
        default: begin rd = 1; wr = 1; a = 32'(4 * $urandom_range(0, 15)); end
      endcase
      if (m_pend) begin rd = 1; wr = 0; a = last_a; end
      last_a = a;
      cycle(rd, wr, a, wd, 8'($urandom), rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
